// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module muldiv_unit #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned OP_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CNT_W   = $clog2(XLEN) + 1;
  localparam int unsigned W_SHIFT = XLEN - 32;

  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_REMU   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MULW   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_DIVW   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_DIVUW  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_REMW   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_REMUW  = OP_W'(12);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] v, input logic w);
    return w ? sext32(v[31:0]) : v;
  endfunction

  // Sign-correct the full product, then pick the half the op asks for.
  function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] p, input logic neg,
                                              input logic hi, input logic w);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    if (w) return sext32(s[31:0]);
    else if (hi) return s[2*XLEN-1:XLEN];
    else return s[XLEN-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic                neg_q, neg_d;
  logic                hi_q, hi_d;
  logic                w_q, w_d;
  logic                rem_q, rem_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  logic dec_mul, dec_div, dec_hi, dec_rem, dec_sa, dec_sb, dec_w;

  // Op decode; W ops only exist on 64-bit builds.
  always_comb begin
    dec_mul = 1'b0;
    dec_div = 1'b0;
    dec_hi  = 1'b0;
    dec_rem = 1'b0;
    dec_sa  = 1'b0;
    dec_sb  = 1'b0;
    dec_w   = 1'b0;
    case (op)
      OP_MUL:    dec_mul = 1'b1;
      OP_MULH:   begin dec_mul = 1'b1; dec_hi = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      OP_MULHSU: begin dec_mul = 1'b1; dec_hi = 1'b1; dec_sa = 1'b1; end
      OP_MULHU:  begin dec_mul = 1'b1; dec_hi = 1'b1; end
      OP_DIV:    begin dec_div = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      OP_DIVU:   dec_div = 1'b1;
      OP_REM:    begin dec_div = 1'b1; dec_rem = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      OP_REMU:   begin dec_div = 1'b1; dec_rem = 1'b1; end
      OP_MULW:   begin dec_mul = 1'b1; dec_w = 1'b1; end
      OP_DIVW:   begin dec_div = 1'b1; dec_w = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      OP_DIVUW:  begin dec_div = 1'b1; dec_w = 1'b1; end
      OP_REMW:   begin dec_div = 1'b1; dec_w = 1'b1; dec_rem = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      OP_REMUW:  begin dec_div = 1'b1; dec_w = 1'b1; dec_rem = 1'b1; end
      default:   ;
    endcase
    if (XLEN != 64 && dec_w) begin
      dec_mul = 1'b0;
      dec_div = 1'b0;
    end
  end

  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val, special_res;
  logic            a_neg, b_neg, div0, ovf;

  // Operand preparation and divide special-case detection.
  always_comb begin
    a_ext   = dec_w ? (dec_sa ? sext32(src_a[31:0]) : XLEN'(src_a[31:0])) : src_a;
    b_ext   = dec_w ? (dec_sb ? sext32(src_b[31:0]) : XLEN'(src_b[31:0])) : src_b;
    a_neg   = dec_sa & a_ext[XLEN-1];
    b_neg   = dec_sb & b_ext[XLEN-1];
    a_abs   = a_neg ? -a_ext : a_ext;
    b_abs   = b_neg ? -b_ext : b_ext;
    min_val = dec_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div0    = (b_ext == '0);
    ovf     = dec_sa & (a_ext == min_val) & (b_ext == '1);
    if (div0) special_res = dec_rem ? a_ext : '1;
    else      special_res = dec_rem ? '0 : a_ext;
    special_res = wfix(special_res, dec_w);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = (2*XLEN)'(a_abs) * (2*XLEN)'(b_abs);
`endif

  logic [XLEN:0]      mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]  mul_next, div_next;
  logic [XLEN-1:0]    div_raw, div_res;
  logic [CNT_W-1:0]   cnt_inc, iters;
  logic               qbit;

  // One radix-2 step of each engine; both share the accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-2:XLEN], acc_q[XLEN-1]} | {acc_q[2*XLEN-1], XLEN'(0)};
    div_diff  = div_shift - {1'b0, mcand_q};
    qbit      = ~div_diff[XLEN];
    div_next  = {(qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], qbit};
    div_raw   = rem_q ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    div_res   = neg_q ? -div_raw : div_raw;
    cnt_inc   = cnt_q + CNT_W'(1);
    iters     = w_q ? CNT_W'(32) : CNT_W'(XLEN);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    w_d      = w_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          hi_d  = dec_hi;
          w_d   = dec_w;
          rem_d = dec_rem;
          cnt_d = '0;
          if (dec_div) begin
            neg_d   = dec_rem ? a_neg : (a_neg ^ b_neg);
            mcand_d = b_abs;
            acc_d   = {XLEN'(0), (dec_w ? (a_abs << W_SHIFT) : a_abs)};
            if (div0 || ovf) begin
              result_d = special_res;
              state_d  = DONE;
            end else begin
              state_d = DIV;
            end
          end else if (dec_mul) begin
            neg_d   = a_neg ^ b_neg;
            mcand_d = a_abs;
            acc_d   = {XLEN'(0), b_abs};
`ifdef MULDIV_FAST_MUL_EN
            result_d = mul_sel(fast_prod, a_neg ^ b_neg, dec_hi, dec_w);
            state_d  = DONE;
`else
            state_d = MUL;
`endif
          end else begin
            result_d = '0;
            state_d  = DONE;
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_inc;
        if (cnt_inc == iters) begin
          // W products sit 32 bits higher after only 32 steps.
          result_d = mul_sel(w_q ? (mul_next >> W_SHIFT) : mul_next, neg_q, hi_q, w_q);
          state_d  = DONE;
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_inc;
        if (cnt_inc == iters) begin
          result_d = wfix(div_res, w_q);
          state_d  = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      neg_q       <= 1'b0;
      hi_q        <= 1'b0;
      w_q         <= 1'b0;
      rem_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      neg_q       <= neg_d;
      hi_q        <= hi_d;
      w_q         <= w_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule
